// File: rtl/fd_reg_pkg.sv
// Shared pipeline constants: address map defaults, exception codes,
// opcode/funct values and the F/D register bundle type.
package fd_reg_pkg;

    localparam logic [31:0] BEGIN_ADDR_DEF   = 32'h0000_3000;
    localparam logic [31:0] HANDLER_ADDR_DEF = 32'h0000_4180;
    localparam logic [31:0] IM_LO_DEF        = 32'h0000_3000;
    localparam logic [31:0] IM_HI_DEF        = 32'h0000_6FFC;

    localparam logic [4:0]  EXC_NONE = 5'd0;
    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [31:0] NOP      = 32'h0;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        bd;
        logic [4:0]  exc;
    } fd_state_t;

endpackage

// File: rtl/fd_reg_if.sv
// F->D boundary bundle.
// master: fetch/hazard side drives stall, flush, F_PC, F_Instr;
// slave: the F/D register drives the D_* outputs.
interface fd_reg_if;

    logic        stall;
    logic        flush;
    logic [31:0] F_PC;
    logic [31:0] F_Instr;
    logic [31:0] D_PC;
    logic [31:0] D_Instr;
    logic        D_Valid;
    logic        D_BD;
    logic [4:0]  D_ExcCode;

    modport master (
        output stall, flush, F_PC, F_Instr,
        input  D_PC, D_Instr, D_Valid, D_BD, D_ExcCode
    );

    modport slave (
        input  stall, flush, F_PC, F_Instr,
        output D_PC, D_Instr, D_Valid, D_BD, D_ExcCode
    );

endinterface

// File: rtl/fd_reg_branch_class.sv
// branch_class: flags branch/jump instructions (REGIMM, J, JAL, BEQ,
// BNE, BLEZ, BGTZ, JR, JALR). Ports: i_instr (32) in, o_is_branch out.
module branch_class
    import fd_reg_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic        o_is_branch
);

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic       w_unused;

    assign w_op     = i_instr[31:26];
    assign w_fn     = i_instr[5:0];
    assign w_unused = ^i_instr[25:6];

    always_comb begin
        o_is_branch = 1'b0;
        unique case (w_op)
            OP_REGIMM, OP_J, OP_JAL, OP_BEQ,
            OP_BNE, OP_BLEZ, OP_BGTZ:
                o_is_branch = 1'b1;
            OP_SPECIAL:
                o_is_branch = (w_fn == FN_JR) ||
                              (w_fn == FN_JALR);
            default:
                o_is_branch = 1'b0;
        endcase
    end

endmodule

// File: rtl/fd_reg.sv
// fd_reg: F/D pipeline register with fetch address check and
// delay-slot tagging. Ports: clk, reset (sync, active-high),
// fd (fd_reg_if.slave: stall/flush/F_* in, D_* out).
module fd_reg
    import fd_reg_pkg::*;
#(
    parameter logic [31:0] BEGIN_ADDR   = BEGIN_ADDR_DEF,
    parameter logic [31:0] HANDLER_ADDR = HANDLER_ADDR_DEF,
    parameter logic [31:0] IM_LO        = IM_LO_DEF,
    parameter logic [31:0] IM_HI        = IM_HI_DEF
) (
    input  logic     clk,
    input  logic     reset,
    fd_reg_if.slave  fd
);

    fd_state_t r_d;
    fd_state_t w_load;
    logic      w_adel;
    logic      w_is_branch;

    // Misaligned or outside instruction memory -> AdEL.
    assign w_adel = (fd.F_PC[1:0] != 2'b00) ||
                    (fd.F_PC < IM_LO) ||
                    (fd.F_PC > IM_HI);

    // Classify what D holds now: the incoming word is its delay slot.
    branch_class u_branch_class (
        .i_instr     (r_d.instr),
        .o_is_branch (w_is_branch)
    );

    always_comb begin
        w_load       = '0;
        w_load.pc    = fd.F_PC;
        w_load.valid = 1'b1;
        w_load.bd    = r_d.valid & w_is_branch;
        w_load.exc   = w_adel ? EXC_ADEL : EXC_NONE;
        w_load.instr = w_adel ? NOP : fd.F_Instr;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_d       <= '0;
            r_d.pc    <= BEGIN_ADDR;
        end else if (fd.flush) begin
            r_d       <= '0;
            r_d.pc    <= HANDLER_ADDR;
        end else if (!fd.stall) begin
            r_d       <= w_load;
        end
    end

    assign fd.D_PC      = r_d.pc;
    assign fd.D_Instr   = r_d.instr;
    assign fd.D_Valid   = r_d.valid;
    assign fd.D_BD      = r_d.bd;
    assign fd.D_ExcCode = r_d.exc;

endmodule

// File: tb/tb_fd_reg.sv
// Self-checking bench for fd_reg: reference model feeds a scoreboard
// queue at drive time; each scenario task pops and compares.
module tb_fd_reg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        bd;
        logic [4:0]  exc;
    } st_t;

    logic clk = 1'b0;
    logic reset;
    int   n_err = 0;
    int   n_chk = 0;
    st_t  m = '0;
    st_t  sb[$];
    st_t  exp_s;
    st_t  act_s;

    fd_reg_if u_if ();

    fd_reg u_dut (
        .clk   (clk),
        .reset (reset),
        .fd    (u_if)
    );

    always #5 clk = ~clk;

    function automatic logic is_br(input logic [31:0] ins);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        if (op >= 6'd1 && op <= 6'd7)
            return 1'b1;
        return (op == 6'd0) && (fn == 6'd8 || fn == 6'd9);
    endfunction

    function automatic st_t model_next(
        input st_t cur, input logic rst, input logic fl,
        input logic stl, input logic [31:0] pc,
        input logic [31:0] ins);
        st_t n;
        logic bad;
        n = cur;
        bad = (pc[1:0] != 2'b00) || (pc < 32'h3000) ||
              (pc > 32'h6FFC);
        if (rst)
            n = {32'h3000, 32'h0, 1'b0, 1'b0, 5'd0};
        else if (fl)
            n = {32'h4180, 32'h0, 1'b0, 1'b0, 5'd0};
        else if (!stl)
            n = {pc, bad ? 32'h0 : ins, 1'b1,
                 cur.valid & is_br(cur.instr),
                 bad ? 5'd4 : 5'd0};
        return n;
    endfunction

    function automatic st_t sample();
        return {u_if.D_PC, u_if.D_Instr, u_if.D_Valid,
                u_if.D_BD, u_if.D_ExcCode};
    endfunction

    function automatic string show(input st_t s);
        return $sformatf("pc=%h ins=%h v=%b bd=%b exc=%0d",
                         s.pc, s.instr, s.valid, s.bd, s.exc);
    endfunction

    task automatic cycle(input logic rst, input logic fl,
                         input logic stl, input logic [31:0] pc,
                         input logic [31:0] ins);
        @(negedge clk);
        reset         = rst;
        u_if.flush    = fl;
        u_if.stall    = stl;
        u_if.F_PC     = pc;
        u_if.F_Instr  = ins;
        m = model_next(m, rst, fl, stl, pc, ins);
        sb.push_back(m);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        cycle(1, 1, 1, 32'h5000, 32'h1000_0001);
        exp_s = sb.pop_front();
        act_s = sample();
        n_chk++;
        if (act_s !== exp_s) begin
            n_err++;
            $display("FAIL reset: got %s required %s",
                     show(act_s), show(exp_s));
        end
        n_chk++;
        if (act_s !== {32'h3000, 32'h0, 1'b0, 1'b0, 5'd0}) begin
            n_err++;
            $display("FAIL reset_const: got %s required pc=3000 rest 0",
                     show(act_s));
        end
    endtask

    task automatic test_load();
        cycle(0, 0, 0, 32'h3000, 32'h3C01_1234);
        exp_s = sb.pop_front();
        act_s = sample();
        n_chk++;
        if (act_s !== exp_s) begin
            n_err++;
            $display("FAIL load: got %s required %s",
                     show(act_s), show(exp_s));
        end
        n_chk++;
        if (act_s !== {32'h3000, 32'h3C01_1234, 1'b1, 1'b0, 5'd0}) begin
            n_err++;
            $display("FAIL load_lui: got %s required pc=3000 ins=3c011234 v=1",
                     show(act_s));
        end
    endtask

    task automatic test_branch();
        logic [31:0] pcs [9];
        logic [31:0] ins [9];
        pcs = '{32'h3004, 32'h3008, 32'h300C, 32'h3010, 32'h3014,
                32'h3018, 32'h301C, 32'h3020, 32'h3024};
        ins = '{32'h1022_0003, 32'h2442_0001, 32'h0000_0000,
                32'h0800_0C00, 32'h1420_0002, 32'h0C00_0C10,
                32'h0040_F809, 32'h0043_0821, 32'h0441_0002};
        for (int i = 0; i < 9; i++) begin
            cycle(0, 0, 0, pcs[i], ins[i]);
            exp_s = sb.pop_front();
            act_s = sample();
            n_chk++;
            if (act_s !== exp_s) begin
                n_err++;
                $display("FAIL branch[%0d]: got %s required %s",
                         i, show(act_s), show(exp_s));
            end
            if (i == 1 || i == 2) begin
                n_chk++;
                if (act_s.bd !== (i == 1)) begin
                    n_err++;
                    $display("FAIL beq_slot[%0d]: got bd=%b required %b",
                             i, act_s.bd, (i == 1));
                end
            end
        end
    endtask

    task automatic test_stall();
        st_t held;
        cycle(0, 0, 0, 32'h3028, 32'h1000_0004);
        void'(sb.pop_front());
        cycle(0, 0, 0, 32'h302C, 32'h1000_0004);
        exp_s = sb.pop_front();
        held = sample();
        n_chk++;
        if (held !== exp_s) begin
            n_err++;
            $display("FAIL stall_pre: got %s required %s",
                     show(held), show(exp_s));
        end
        for (int i = 0; i < 3; i++) begin
            cycle(0, 0, 1, 32'h3100 + 32'(i * 4), 32'h2442_0000 + i);
            exp_s = sb.pop_front();
            act_s = sample();
            n_chk++;
            if (act_s !== exp_s || act_s !== held || act_s.bd !== 1'b1) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got %s required %s",
                         i, show(act_s), show(held));
            end
        end
        cycle(0, 0, 0, 32'h3030, 32'h2442_0000);
        exp_s = sb.pop_front();
        act_s = sample();
        n_chk++;
        if (act_s !== exp_s || act_s.bd !== 1'b1) begin
            n_err++;
            $display("FAIL stall_release: got %s required %s",
                     show(act_s), show(exp_s));
        end
    endtask

    task automatic test_adel();
        logic [31:0] pcs [6];
        logic [31:0] ins [6];
        pcs = '{32'h3002, 32'h7000, 32'h2FFC, 32'h6FFC,
                32'h1000_0000, 32'h3034};
        ins = '{32'h1000_0001, 32'h2442_0001, 32'h2442_0002,
                32'h1000_0002, 32'h2442_0003, 32'h2442_0004};
        for (int i = 0; i < 6; i++) begin
            cycle(0, 0, 0, pcs[i], ins[i]);
            exp_s = sb.pop_front();
            act_s = sample();
            n_chk++;
            if (act_s !== exp_s) begin
                n_err++;
                $display("FAIL adel[%0d]: got %s required %s",
                         i, show(act_s), show(exp_s));
            end
        end
        cycle(0, 0, 0, 32'h3002, 32'h2442_0000);
        exp_s = sb.pop_front();
        act_s = sample();
        n_chk++;
        if (act_s.instr !== 32'h0 || act_s.exc !== 5'd4 ||
            act_s.valid !== 1'b1 || act_s !== exp_s) begin
            n_err++;
            $display("FAIL adel_misalign: got %s required %s",
                     show(act_s), show(exp_s));
        end
    endtask

    task automatic test_flush();
        cycle(0, 0, 0, 32'h3040, 32'h03E0_0008);
        void'(sb.pop_front());
        cycle(0, 1, 1, 32'h3044, 32'h2442_0000);
        exp_s = sb.pop_front();
        act_s = sample();
        n_chk++;
        if (act_s !== exp_s ||
            act_s !== {32'h4180, 32'h0, 1'b0, 1'b0, 5'd0}) begin
            n_err++;
            $display("FAIL flush_stall: got %s required %s",
                     show(act_s), show(exp_s));
        end
        cycle(0, 0, 0, 32'h4180, 32'h2442_0000);
        exp_s = sb.pop_front();
        act_s = sample();
        n_chk++;
        if (act_s !== exp_s) begin
            n_err++;
            $display("FAIL flush_next: got %s required %s",
                     show(act_s), show(exp_s));
        end
    endtask

    task automatic test_reset_priority();
        cycle(0, 0, 0, 32'h3050, 32'h03E0_0008);
        void'(sb.pop_front());
        cycle(1, 1, 1, 32'h3054, 32'h2442_0000);
        exp_s = sb.pop_front();
        act_s = sample();
        n_chk++;
        if (act_s !== exp_s ||
            act_s !== {32'h3000, 32'h0, 1'b0, 1'b0, 5'd0}) begin
            n_err++;
            $display("FAIL reset_prio: got %s required %s",
                     show(act_s), show(exp_s));
        end
        cycle(0, 0, 0, 32'h3000, 32'h2442_0000);
        exp_s = sb.pop_front();
        act_s = sample();
        n_chk++;
        if (act_s !== exp_s || act_s.bd !== 1'b0) begin
            n_err++;
            $display("FAIL reset_bd: got %s required %s",
                     show(act_s), show(exp_s));
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] itab [6];
        logic [31:0] pc;
        logic        rst;
        logic        fl;
        logic        stl;
        itab = '{32'h1022_0003, 32'h03E0_0008, 32'h2442_0001,
                 32'h0800_0C00, 32'h0043_0821, 32'h1C20_0001};
        for (int i = 0; i < 60; i++) begin
            rst = ($urandom_range(0, 24) == 0);
            fl  = ($urandom_range(0, 9) == 0);
            stl = ($urandom_range(0, 3) == 0);
            pc  = 32'h3000 + 32'($urandom_range(0, 15) * 4);
            case ($urandom_range(0, 7))
                0: pc = pc + 32'd1;
                1: pc = 32'h6FFC;
                2: pc = 32'h7000;
                3: pc = 32'h2FFC;
                default: ;
            endcase
            cycle(rst, fl, stl, pc, itab[$urandom_range(0, 5)]);
            exp_s = sb.pop_front();
            act_s = sample();
            n_chk++;
            if (act_s !== exp_s) begin
                n_err++;
                $display("FAIL b2b[%0d]: got %s required %s",
                         i, show(act_s), show(exp_s));
            end
        end
    endtask

    initial begin
        reset        = 1'b1;
        u_if.flush   = 1'b0;
        u_if.stall   = 1'b0;
        u_if.F_PC    = 32'h0;
        u_if.F_Instr = 32'h0;
        test_reset();
        test_load();
        test_branch();
        test_stall();
        test_adel();
        test_flush();
        test_reset_priority();
        test_back_to_back();
        n_chk++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left required 0",
                     sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/fd_reg.md
FD_REG -- requirements
Module: fd_reg

Interface
REQ-001 Parameter BEGIN_ADDR, 32'h0000_3000, D_PC value after reset.
REQ-002 Parameter HANDLER_ADDR, 32'h0000_4180, D_PC value loaded on flush.
REQ-003 Parameter IM_LO, 32'h0000_3000, lowest legal fetch address.
REQ-004 Parameter IM_HI, 32'h0000_6FFC, highest legal fetch address.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 stall  input  1  D-stage stall from hazard unit; 1 = hold contents.
REQ-008 flush  input  1  exception/interrupt request; 1 = clear to bubble.
REQ-009 F_PC  input  32  PC currently in F stage.
REQ-010 F_Instr  input  32  instruction word read at F_PC.
REQ-011 D_PC  output  32  registered PC of D-stage instruction.
REQ-012 D_Instr  output  32  registered D-stage instruction (NOP = 32'h0).
REQ-013 D_Valid  output  1  1 = D holds a real fetched instruction.
REQ-014 D_BD  output  1  1 = D instruction sits in a branch delay slot.
REQ-015 D_ExcCode  output  5  fetch exception code; 0 = none, 4 = AdEL.

Function
REQ-016 Update priority each edge SHALL be: reset > flush > stall > load.
REQ-017 Load SHALL capture D_PC<=F_PC, D_Valid<=1, D_ExcCode<=fetch_exc, D_BD<=bd_next, D_Instr<=(fetch_exc?0:F_Instr).
REQ-018 fetch_exc SHALL be 4 when F_PC[1:0]!=0 or F_PC<IM_LO or F_PC>IM_HI (unsigned compare), else 0.
REQ-019 bd_next SHALL be 1 iff D_Valid=1 and current D_Instr is branch/jump class, evaluated from pre-edge D contents.
REQ-020 Branch/jump class SHALL be opcode 000001, 000010, 000011, 000100, 000101, 000110, 000111, or opcode 000000 with funct 001000 or 001001.
REQ-021 Stall SHALL hold all five outputs unchanged, including D_BD; bd_next is not re-evaluated while held.
REQ-022 Flush SHALL load D_PC<=HANDLER_ADDR, D_Instr<=0, D_Valid<=0, D_BD<=0, D_ExcCode<=0, regardless of stall.
REQ-023 Latency SHALL be one cycle F to D; outputs driven directly from flops, no combinational input-to-output path.
REQ-024 A faulting fetch SHALL still set D_Valid=1 so the exception reaches the commit point; its D_BD follows REQ-019.
REQ-025 After a faulting fetch, bd_next for the next load SHALL be 0, since D_Instr=0 is not branch class.
REQ-026 Consecutive branches SHALL each be tagged per REQ-019 with no suppression.

Reset
REQ-027 On reset: D_PC=BEGIN_ADDR, D_Instr=0, D_Valid=0, D_BD=0, D_ExcCode=0.
REQ-028 Reset asserted during stall or flush SHALL win; first load after reset release SHALL give D_BD=0.
REQ-029 No initial blocks are relied on for function; reset alone defines state.

Structure
REQ-030 Parameter defaults, EXC_ADEL=5'd4, and opcode/funct constants SHALL live in the shared macro header used by all pipeline stages.
REQ-031 One sub-module, branch_class (combinational, 32-bit instr in, 1-bit is_branch out), SHALL implement REQ-020 and be reusable by the NPC/compare logic.
REQ-032 fd_reg SHALL contain only the state register, the priority mux, the address checker and one branch_class instance.

Verification
REQ-033 Reset then F_PC=0x3000, F_Instr=0x3C011234 (lui) with no stall -> next edge D_PC=0x3000, D_Instr=0x3C011234, D_Valid=1, D_BD=0, D_ExcCode=0.
REQ-034 Load beq 0x10220003 at 0x3004, then 0x3008 -> D_BD=1 for 0x3008; next instr at 0x300C -> D_BD=0.
REQ-035 Hold stall=1 for 3 cycles while F changes -> D outputs frozen at prior values; D_BD stays 1 if it was 1.
REQ-036 F_PC=0x3002 -> D_Instr=0, D_ExcCode=4, D_Valid=1; F_PC=0x7000 -> D_ExcCode=4, D_Instr=0.
REQ-037 flush=1 and stall=1 together -> D_PC=0x4180, D_Instr=0, D_Valid=0, D_BD=0, D_ExcCode=0.
REQ-038 reset=1 with flush=1 and stall=1 -> D_PC=0x3000, all other outputs 0; jr 0x03E00008 in D then reset -> next load gives D_BD=0.
